// File: rtl/vga_draw_arbiter_pkg.sv
// Shared constants and FSM encoding for the VGA draw arbiter; also used to
// configure main and the vga_adapter. Optional build macro: VGA_DRAW_CLEAR_ON_RESET_EN.
package vga_draw_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_XW    = 8;
    localparam int DEF_YW    = 7;
    localparam int DEF_CW    = 3;
    localparam int DEF_H_RES = 160;
    localparam int DEF_V_RES = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FIN   = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // Index width for an n-way selector; a single requester still needs one bit.
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Requester-side rectangle requests plus the shared pixel-write port.
// The master modport is the game logic / adapter side, slave is the arbiter.
interface vga_draw_arbiter_if #(
    parameter int N  = 4,
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
);
    logic [N-1:0]    req;
    logic [N*XW-1:0] rect_x;
    logic [N*YW-1:0] rect_y;
    logic [N*XW-1:0] rect_w;
    logic [N*YW-1:0] rect_h;
    logic [N*CW-1:0] rect_colour;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;
    logic            vga_plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or above the pointer,
// wrapping around. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares one VGA pixel-write port between N rectangle-fill requesters.
// Optional build macro: VGA_DRAW_CLEAR_ON_RESET_EN (blank the screen after reset).
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int XW    = DEF_XW,
    parameter int YW    = DEF_YW,
    parameter int CW    = DEF_CW,
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES
) (
    input  logic               clock,
    input  logic               resetn,
    vga_draw_arbiter_if.slave  bus
);

    localparam int IW = idx_w(N);
`ifdef VGA_DRAW_CLEAR_ON_RESET_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    done_q, done_d;
    logic [XW-1:0]   x0_q, x0_d, w_q, w_d, cx_q, cx_d;
    logic [YW-1:0]   y0_q, y0_d, h_q, h_d, cy_q, cy_d;
    logic [CW-1:0]   col_q, col_d;
    logic [XW-1:0]   vga_x_q, vga_x_d;
    logic [YW-1:0]   vga_y_q, vga_y_d;
    logic [CW-1:0]   vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;

    logic [N-1:0]    pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [XW:0]     sum_x;
    logic [YW:0]     sum_y;

    // Coordinates are summed one bit wider so off-screen pixels are detected, not wrapped.
    function automatic logic on_screen(logic [XW:0] sx, logic [YW:0] sy);
        return (sx < (XW+1)'(H_RES)) && (sy < (YW+1)'(V_RES));
    endfunction

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RESET_STATE;
            ptr_q        <= '0;
            sel_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            col_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            w_q          <= w_d;
            h_q          <= h_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            col_q        <= col_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick_idx;
                    grant_d = pick_gnt;
                    x0_d    = bus.rect_x[int'(pick_idx)*XW +: XW];
                    y0_d    = bus.rect_y[int'(pick_idx)*YW +: YW];
                    w_d     = bus.rect_w[int'(pick_idx)*XW +: XW];
                    h_d     = bus.rect_h[int'(pick_idx)*YW +: YW];
                    col_d   = bus.rect_colour[int'(pick_idx)*CW +: CW];
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (w_d == '0 || h_d == '0) ? ST_FIN : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (cx_q == w_q - 1'b1) begin
                    cx_d = '0;
                    if (cy_q == h_q - 1'b1) state_d = ST_FIN;
                    else                    cy_d = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            ST_FIN: begin
                grant_d = '0;
                ptr_d   = (int'(sel_q) == N-1) ? '0 : sel_q + 1'b1;
                state_d = ST_IDLE;
            end
`ifdef VGA_DRAW_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                if (cx_q == XW'(H_RES-1)) begin
                    cx_d = '0;
                    if (cy_q == YW'(V_RES-1)) begin
                        cy_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so the first pixel shows
    // the cycle right after the request is sampled.
    always_comb begin
        sum_x        = {1'b0, x0_d} + {1'b0, cx_d};
        sum_y        = {1'b0, y0_d} + {1'b0, cy_d};
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        done_d       = (state_d == ST_FIN) ? grant_d : '0;
        if (state_d == ST_DRAW) begin
            vga_x_d      = sum_x[XW-1:0];
            vga_y_d      = sum_y[YW-1:0];
            vga_colour_d = col_d;
            vga_plot_d   = on_screen(sum_x, sum_y);
        end
`ifdef VGA_DRAW_CLEAR_ON_RESET_EN
        if (state_q == ST_CLEAR) begin
            vga_x_d      = cx_q;
            vga_y_d      = cy_q;
            vga_colour_d = '0;
            vga_plot_d   = 1'b1;
        end
`endif
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    // The last clear pixel is still on the port during the first IDLE cycle.
    assign bus.busy       = (state_q != ST_IDLE) || vga_plot_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: expected pixels are queued when a
// request is raised and matched against every plot pulse.
module tb_vga_draw_arbiter;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    vga_draw_arbiter_if #(.N(N), .XW(XW), .YW(YW), .CW(CW)) bus ();

    vga_draw_arbiter #(
        .N(N), .XW(XW), .YW(YW), .CW(CW), .H_RES(160), .V_RES(120)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [XW+YW+CW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetn && bus.vga_plot) begin
            if (exp_q.size() == 0)
                check("pixel_extra", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'hFFFF_FFFF);
            else
                check("pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(exp_q.pop_front()));
        end
    end

    task automatic set_rect(input int i, input int x, input int y, input int w,
                            input int h, input int c, input int limit);
        int n;
        n = 0;
        bus.rect_x[i*XW +: XW]      = XW'(x);
        bus.rect_y[i*YW +: YW]      = YW'(y);
        bus.rect_w[i*XW +: XW]      = XW'(w);
        bus.rect_h[i*YW +: YW]      = YW'(h);
        bus.rect_colour[i*CW +: CW] = CW'(c);
        bus.req[i]                  = 1'b1;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                if (n < limit && x + xx < 160 && y + yy < 120) begin
                    exp_q.push_back({XW'(x + xx), YW'(y + yy), CW'(c)});
                    n++;
                end
    endtask

    task automatic wait_done(input int i, input int exp_k, input string tag);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 2000) begin
            @(negedge clock);
            k++;
            if (k == 1) check({tag, "_grant_start"}, 32'(bus.grant), 32'(1 << i));
            if (bus.done != '0) seen = 1'b1;
        end
        check({tag, "_done_cycle"}, 32'(k), 32'(exp_k));
        if (!seen) return;
        check({tag, "_done"}, 32'(bus.done), 32'(1 << i));
        check({tag, "_grant_fin"}, 32'(bus.grant), 32'(1 << i));
        check({tag, "_plot_fin"}, 32'(bus.vga_plot), 32'd0);
        bus.req[i] = 1'b0;
        @(negedge clock);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_plot"}, 32'(bus.vga_plot), 32'd0);
        check({tag, "_xyc"}, 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req         = '0;
        bus.rect_x      = '0;
        bus.rect_y      = '0;
        bus.rect_w      = '0;
        bus.rect_h      = '0;
        bus.rect_colour = '0;
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        resetn = 1'b1;
        @(negedge clock);

        // Simultaneous req0/req2 from pointer 0, then req0/req1 from pointer 3.
        set_rect(0, 10, 10, 1, 1, 1, 1000);
        set_rect(2, 20, 20, 1, 1, 2, 1000);
        wait_done(0, 2, "arb0");
        wait_done(2, 2, "arb2");
        set_rect(0, 30, 30, 1, 1, 3, 1000);
        set_rect(1, 40, 40, 1, 1, 4, 1000);
        wait_done(0, 2, "wrap0");
        wait_done(1, 2, "wrap1");

        set_rect(0, 4, 4, 2, 2, 4, 1000);
        wait_done(0, 5, "rect2x2");

        set_rect(1, 50, 50, 0, 5, 7, 1000);
        wait_done(1, 1, "zero_w");

        set_rect(3, 158, 119, 4, 2, 5, 1000);
        wait_done(3, 9, "clip");
        check("sb_empty_a", 32'(exp_q.size()), 32'd0);

        // Reset while pixel 20 of a 10x10 fill is on the port.
        set_rect(0, 20, 20, 10, 10, 6, 20);
        repeat (20) @(negedge clock);
        #1 resetn = 1'b0;
        #1 check_outputs_zero("midreset");
        bus.req = '0;
        repeat (3) begin
            @(negedge clock);
            check("midreset_no_done", 32'(bus.done), 32'd0);
        end
        resetn = 1'b1;
        check("sb_empty_b", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        set_rect(2, 60, 60, 3, 2, 2, 1000);
        wait_done(2, 7, "post_reset");
        check("sb_empty_c", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
